// File: rtl/instr_loop_sequencer_if.sv
// AXI-Stream instruction bus between the loop sequencer and the experiment FSM.
// The sequencer drives tdata/tvalid, and the FSM answers with tready.
interface instr_loop_sequencer_if #(
  parameter int DW = 16
);
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/instr_loop_sequencer.sv
// Program-memory instruction sequencer: pulses run_trig, then streams the loaded program
// loop_count times on an AXI-Stream bus. Optional SEQ_INSTR_CNT_EN adds the instr_cnt port.
module instr_loop_sequencer #(
  parameter int AW     = 8,
  parameter int DW     = 16,
  parameter int ACK_TO = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   prog_wr_en,
  input  logic [AW-1:0]          prog_wr_addr,
  input  logic [DW-1:0]          prog_wr_data,
  input  logic [AW:0]            prog_len,
  input  logic [15:0]            loop_count,
  output logic                   run_trig,
  input  logic                   run_done,
  instr_loop_sequencer_if.master instr_axis,
  output logic                   halt,
  output logic                   busy,
  output logic                   seq_done,
  output logic                   seq_err,
  output logic [15:0]            loop_idx
`ifdef SEQ_INSTR_CNT_EN
  ,
  output logic [31:0]            instr_cnt
`endif
);

  localparam int          TW    = $clog2(ACK_TO + 1);
  localparam logic [AW:0] DEPTH = (AW + 1)'(2 ** AW);

  typedef enum logic [2:0] {IDLE, TRIG, ACK, STREAM, DRAIN} state_t;

  state_t        state, state_next;
  logic [DW-1:0] mem [2 ** AW];
  logic [AW-1:0] addr, last_addr, addr_inc;
  logic [16:0]   total_loops, loops_done;
  logic [TW-1:0] ack_cnt;
  logic [DW-1:0] tdata_r;
  logic          tvalid_r;
  logic          len_bad, fire, at_wrap, last_loop, ack_timeout;

  assign len_bad     = (prog_len == '0) || (prog_len > DEPTH);
  assign fire        = tvalid_r && instr_axis.tready;
  assign at_wrap     = (addr == last_addr);
  assign last_loop   = (loops_done == total_loops - 17'd1);
  assign ack_timeout = (ack_cnt == TW'(ACK_TO - 1));
  assign addr_inc    = addr + AW'(1);

  assign run_trig          = (state == TRIG);
  assign busy              = (state != IDLE);
  assign loop_idx          = loops_done[15:0];
  assign instr_axis.tdata  = tdata_r;
  assign instr_axis.tvalid = tvalid_r;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start && !len_bad) state_next = TRIG;
      TRIG:    state_next = abort ? DRAIN : ACK;
      ACK: begin
        if (abort)            state_next = DRAIN;
        else if (!run_done)   state_next = STREAM;
        else if (ack_timeout) state_next = IDLE;
      end
      STREAM:  if (abort || (fire && at_wrap && last_loop)) state_next = DRAIN;
      DRAIN:   if (run_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Program RAM is only writable while idle so a running sequence never sees a torn program.
  always_ff @(posedge clk) begin
    if (prog_wr_en && state == IDLE) mem[prog_wr_addr] <= prog_wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr        <= '0;
      last_addr   <= '0;
      total_loops <= '0;
      loops_done  <= '0;
      ack_cnt     <= '0;
      tdata_r     <= '0;
      tvalid_r    <= 1'b0;
      halt        <= 1'b1;
      seq_done    <= 1'b0;
      seq_err     <= 1'b0;
    end else begin
      seq_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && len_bad) begin
            seq_err  <= 1'b1;
            seq_done <= 1'b1;
          end else if (start) begin
            last_addr   <= AW'(prog_len - 1'b1);
            total_loops <= (loop_count == 16'd0) ? 17'h10000 : {1'b0, loop_count};
            loops_done  <= '0;
            addr        <= '0;
            ack_cnt     <= '0;
            seq_err     <= 1'b0;
            halt        <= 1'b0;
          end
        end
        TRIG: begin
          ack_cnt <= '0;
          if (abort) halt <= 1'b1;
        end
        ACK: begin
          if (abort) begin
            halt <= 1'b1;
          end else if (!run_done) begin
            tdata_r  <= mem[0];
            tvalid_r <= 1'b1;
            addr     <= '0;
          end else if (ack_timeout) begin
            seq_err  <= 1'b1;
            halt     <= 1'b1;
            seq_done <= 1'b1;
          end else begin
            ack_cnt <= ack_cnt + TW'(1);
          end
        end
        STREAM: begin
          // The next word is fetched on the accepting edge so transfers can run every cycle.
          if (fire && at_wrap) begin
            addr       <= '0;
            loops_done <= loops_done + 17'd1;
            tdata_r    <= mem[0];
          end else if (fire) begin
            addr    <= addr_inc;
            tdata_r <= mem[addr_inc];
          end
          if (abort || (fire && at_wrap && last_loop)) begin
            tvalid_r <= 1'b0;
            halt     <= 1'b1;
          end
        end
        DRAIN: if (run_done) seq_done <= 1'b1;
        default: ;
      endcase
    end
  end

`ifdef SEQ_INSTR_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                      instr_cnt <= '0;
    else if (state == IDLE && start && !len_bad)  instr_cnt <= '0;
    else if (fire && instr_cnt != '1)             instr_cnt <= instr_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_instr_loop_sequencer.sv
// Self-checking bench for instr_loop_sequencer: directed scenarios plus randomized programs
// and tready patterns, checked against a program/loop model held in the bench.
module tb_instr_loop_sequencer;
  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, abort, prog_wr_en;
  logic [AW-1:0] prog_wr_addr;
  logic [DW-1:0] prog_wr_data;
  logic [AW:0]   prog_len;
  logic [15:0]   loop_count;
  logic          run_trig, run_done, halt, busy, seq_done, seq_err;
  logic [15:0]   loop_idx;
`ifdef SEQ_INSTR_CNT_EN
  logic [31:0]   instr_cnt;
`endif

  instr_loop_sequencer_if #(.DW(DW)) axis ();

  int            total = 0;
  int            bad   = 0;
  logic [DW-1:0] prog_model [2 ** AW];

  always #5 clk = ~clk;

  instr_loop_sequencer #(.AW(AW), .DW(DW), .ACK_TO(15)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .prog_wr_en   (prog_wr_en),
    .prog_wr_addr (prog_wr_addr),
    .prog_wr_data (prog_wr_data),
    .prog_len     (prog_len),
    .loop_count   (loop_count),
    .run_trig     (run_trig),
    .run_done     (run_done),
    .instr_axis   (axis.master),
    .halt         (halt),
    .busy         (busy),
    .seq_done     (seq_done),
    .seq_err      (seq_err),
    .loop_idx     (loop_idx)
`ifdef SEQ_INSTR_CNT_EN
    ,
    .instr_cnt    (instr_cnt)
`endif
  );

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic write_prog(input int a, input logic [DW-1:0] d);
    @(negedge clk);
    prog_wr_en   = 1'b1;
    prog_wr_addr = AW'(a);
    prog_wr_data = d;
    @(negedge clk);
    prog_wr_en   = 1'b0;
    prog_model[a] = d;
  endtask

  // One full sequence; ready_mode 0=always, 1=toggle, 2=random; abort_after>0 aborts after that many words.
  task automatic apply_stimulus(input int len, input int cnt, input int ready_mode,
                                input int abort_after, input bit wr_during);
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] prev_data = '0;
    int  acc = 0, cyc = 0, trig_cnt = 0, first_acc = -1, last_acc = -1;
    int  ack_wait = -1, drain_wait = 0;
    bit  done = 0, aborted = 0, abort_chk = 0, prev_stall = 0, wrote = 0, drain_started = 0;
    int  n_loops = (cnt == 0) ? 65536 : cnt;
    for (int l = 0; l < n_loops; l++)
      for (int i = 0; i < len; i++) exp_q.push_back(prog_model[i]);

    @(negedge clk);
    prog_len   = (AW + 1)'(len);
    loop_count = 16'(cnt);
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_output("seq_err_cleared", {31'd0, seq_err}, 32'd0);

    while (!done && cyc < 3000) begin
      if (run_trig) begin
        trig_cnt++;
        ack_wait = $urandom_range(0, 3);
      end
      if (ack_wait == 0) begin
        run_done = 1'b0;
        ack_wait = -1;
      end else if (ack_wait > 0) ack_wait--;

      if (halt && trig_cnt > 0 && !drain_started) begin
        drain_started = 1;
        drain_wait    = 2;
      end
      if (drain_started && drain_wait == 0) run_done = 1'b1;
      else if (drain_started) drain_wait--;

      if (abort_chk) begin
        check_output("abort_tvalid", {31'd0, axis.tvalid}, 32'd0);
        check_output("abort_halt", {31'd0, halt}, 32'd1);
        check_output("abort_busy", {31'd0, busy}, 32'd1);
        abort_chk = 0;
      end
      abort = 1'b0;
      if (abort_after > 0 && !aborted && acc == abort_after) begin
        abort     = 1'b1;
        aborted   = 1;
        abort_chk = 1;
      end

      if (prev_stall) begin
        check_output("stall_tvalid", {31'd0, axis.tvalid}, 32'd1);
        check_output("stall_tdata", {16'd0, axis.tdata}, {16'd0, prev_data});
      end

      case (ready_mode)
        0:       axis.tready = 1'b1;
        1:       axis.tready = (cyc % 2 == 0);
        default: axis.tready = 1'($urandom_range(0, 1));
      endcase

      if (axis.tvalid && axis.tready) begin
        if (acc < exp_q.size())
          check_output($sformatf("word%0d", acc), {16'd0, axis.tdata}, {16'd0, exp_q[acc]});
        else
          check_output("extra_word", acc, exp_q.size());
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
        acc++;
      end
      prev_stall = axis.tvalid && !axis.tready;
      prev_data  = axis.tdata;

      prog_wr_en = 1'b0;
      if (wr_during && !wrote && acc == 2) begin
        prog_wr_en   = 1'b1;
        prog_wr_addr = '0;
        prog_wr_data = ~prog_model[0];
        wrote        = 1;
      end

      if (seq_done) begin
        done = 1;
        check_output("busy_at_done", {31'd0, busy}, 32'd0);
        check_output("halt_at_done", {31'd0, halt}, 32'd1);
      end
      cyc++;
      @(negedge clk);
    end
    prog_wr_en = 1'b0;

    if (!done) check_output("seq_done_timeout", 32'd0, 32'd1);
    check_output("trig_once", trig_cnt, 1);
    if (abort_after > 0) begin
      check_output("loop_idx_abort", {16'd0, loop_idx}, acc / len);
    end else begin
      check_output("word_count", acc, exp_q.size());
      check_output("loop_idx", {16'd0, loop_idx}, n_loops % 65536);
    end
    if (ready_mode == 0 && abort_after == 0)
      check_output("back_to_back", last_acc - first_acc, exp_q.size() - 1);
`ifdef SEQ_INSTR_CNT_EN
    check_output("instr_cnt", instr_cnt, acc);
`endif
    check_output("seq_done_pulse", {31'd0, seq_done}, 32'd0);
  endtask

  initial begin
    int n;
    int rlen, rcnt;
    int bad_lens[2] = '{0, 257};
    rst = 1'b1; start = 1'b0; abort = 1'b0; prog_wr_en = 1'b0;
    prog_wr_addr = '0; prog_wr_data = '0; prog_len = '0; loop_count = '0;
    run_done = 1'b1; axis.tready = 1'b0;
    #12;
    check_output("rst_halt", {31'd0, halt}, 32'd1);
    check_output("rst_busy", {31'd0, busy}, 32'd0);
    check_output("rst_tvalid", {31'd0, axis.tvalid}, 32'd0);
    check_output("rst_run_trig", {31'd0, run_trig}, 32'd0);
    check_output("rst_seq_err", {31'd0, seq_err}, 32'd0);
    check_output("rst_seq_done", {31'd0, seq_done}, 32'd0);
    check_output("rst_loop_idx", {16'd0, loop_idx}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    write_prog(0, 16'h0007);
    write_prog(1, 16'h0018);
    write_prog(2, 16'h0080);
    apply_stimulus(3, 2, 0, 0, 0);
    apply_stimulus(3, 2, 1, 0, 0);

    foreach (bad_lens[k]) begin
      @(negedge clk);
      prog_len = (AW + 1)'(bad_lens[k]);
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_output($sformatf("badlen%0d_err", bad_lens[k]), {31'd0, seq_err}, 32'd1);
      check_output($sformatf("badlen%0d_done", bad_lens[k]), {31'd0, seq_done}, 32'd1);
      check_output($sformatf("badlen%0d_trig", bad_lens[k]), {31'd0, run_trig}, 32'd0);
      check_output($sformatf("badlen%0d_busy", bad_lens[k]), {31'd0, busy}, 32'd0);
      @(negedge clk);
      check_output("badlen_done_pulse", {31'd0, seq_done}, 32'd0);
      check_output("badlen_busy_after", {31'd0, busy}, 32'd0);
    end

    apply_stimulus(3, 5, 0, 4, 0);

    @(negedge clk);
    prog_len = 9'd3; loop_count = 16'd1; run_done = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_output("to_trig", {31'd0, run_trig}, 32'd1);
    n = 0;
    while (!seq_err && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_output("to_cycles", n, 16);
    check_output("to_halt", {31'd0, halt}, 32'd1);
    check_output("to_busy", {31'd0, busy}, 32'd0);
    check_output("to_seq_done", {31'd0, seq_done}, 32'd1);

    apply_stimulus(3, 2, 2, 0, 1);
    apply_stimulus(3, 2, 2, 0, 0);

    for (int it = 0; it < 4; it++) begin
      rlen = $urandom_range(1, 6);
      rcnt = $urandom_range(1, 3);
      for (int i = 0; i < rlen; i++) write_prog(i, DW'($urandom));
      apply_stimulus(rlen, rcnt, 2, 0, 0);
    end

    @(negedge clk);
    prog_len = 9'd4; loop_count = 16'd1; run_done = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_output("midrst_busy", {31'd0, busy}, 32'd0);
    check_output("midrst_halt", {31'd0, halt}, 32'd1);
    check_output("midrst_tvalid", {31'd0, axis.tvalid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
